// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the two-port memory request arbiter.
package mem_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  localparam int unsigned MSG_TYPE_NBITS = 3;
  localparam int unsigned MSG_TEST_NBITS = 2;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned count_nbits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned len_nbits(input int unsigned data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  function automatic int unsigned req_msg_nbits(input int unsigned o, input int unsigned a,
                                                input int unsigned d);
    return MSG_TYPE_NBITS + o + a + len_nbits(d) + d;
  endfunction

  function automatic int unsigned resp_msg_nbits(input int unsigned o, input int unsigned d);
    return MSG_TYPE_NBITS + o + MSG_TEST_NBITS + len_nbits(d) + d;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order queue of requester IDs for requests in flight to memory.
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_depth = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output port_id_t head
);

  localparam int unsigned PTR_W = $clog2(p_depth);
  localparam int unsigned CNT_W = count_nbits(p_depth);

  port_id_t         slots [p_depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Full/empty are registered from the next count so they leave the block as flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(p_depth));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/mem_req_arb_2port.sv
// Round-robin arbiter sharing one memory port between two requesters,
// with in-order response routing through a tag FIFO.
module mem_req_arb_2port
  import mem_arb_pkg::*;
#(
  parameter  int unsigned p_opaque_nbits    = 8,
  parameter  int unsigned p_addr_nbits      = 32,
  parameter  int unsigned p_data_nbits      = 32,
  parameter  int unsigned p_max_outstanding = 4,
  localparam int unsigned c_req_nbits  = req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
  localparam int unsigned c_resp_nbits = resp_msg_nbits(p_opaque_nbits, p_data_nbits)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [c_req_nbits-1:0]  req0_msg,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [c_req_nbits-1:0]  req1_msg,

  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic [c_resp_nbits-1:0] resp0_msg,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [c_resp_nbits-1:0] resp1_msg,

  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic [c_req_nbits-1:0]  memreq_msg,

  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [c_resp_nbits-1:0] memresp_msg
);

  localparam int unsigned CNT_W = count_nbits(p_max_outstanding);

  port_id_t         prio;
  port_id_t         grant_id;
  port_id_t         tag_head;
  logic             grant0;
  logic             grant1;
  logic             tag_full;
  logic             tag_empty;
  logic             head_ok;
  logic             req_fire;
  logic             resp_fire;
  logic [CNT_W-1:0] outstanding;

  // Request side: pointed port wins a tie; every handshake output is held low in reset.
  always_comb begin
    grant0     = req0_val && (!req1_val || prio == PORT0);
    grant1     = req1_val && (!req0_val || prio == PORT1);
    grant_id   = grant1 ? PORT1 : PORT0;
    memreq_val = reset && (req0_val || req1_val) && !tag_full;
    memreq_msg = grant1 ? req1_msg : req0_msg;
    req0_rdy   = reset && grant0 && memreq_rdy && !tag_full;
    req1_rdy   = reset && grant1 && memreq_rdy && !tag_full;
    req_fire   = memreq_val && memreq_rdy;
  end

  // Response side: the oldest outstanding tag decides the destination.
  always_comb begin
    head_ok     = reset && !tag_empty;
    resp0_val   = memresp_val && head_ok && (tag_head == PORT0);
    resp1_val   = memresp_val && head_ok && (tag_head == PORT1);
    resp0_msg   = memresp_msg;
    resp1_msg   = memresp_msg;
    memresp_rdy = head_ok && ((tag_head == PORT0) ? resp0_rdy : resp1_rdy);
    resp_fire   = memresp_val && memresp_rdy;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio <= PORT0;
    end else if (req_fire) begin
      prio <= ~grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  mem_arb_tag_fifo #(
    .p_depth (p_max_outstanding)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (req_fire),
    .push_id (grant_id),
    .pop     (resp_fire),
    .full    (tag_full),
    .empty   (tag_empty),
    .head    (tag_head)
  );

  // Protocol and counter sanity while out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(req_fire && !resp_fire && outstanding == CNT_W'(p_max_outstanding)));
      assert (!(resp_fire && !req_fire && outstanding == '0));
      assert (!(memresp_val && tag_empty));
      assert (!$isunknown(req0_val));
      assert (!$isunknown(req1_val));
      assert (!$isunknown(resp0_rdy));
      assert (!$isunknown(resp1_rdy));
      assert (!$isunknown(memreq_rdy));
      assert (!$isunknown(memresp_val));
    end
  end

endmodule

// File: tb/tb_mem_req_arb_2port.sv
// Scoreboard bench: directed traffic on both requesters with an in-order memory model.
module tb_mem_req_arb_2port;

  localparam int unsigned Q = 77;
  localparam int unsigned P = 47;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_val, req0_rdy, req1_val, req1_rdy;
  logic [Q-1:0] req0_msg, req1_msg, memreq_msg;
  logic         resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [P-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;

  always #5 clk = ~clk;

  mem_req_arb_2port #(
    .p_opaque_nbits    (8),
    .p_addr_nbits      (32),
    .p_data_nbits      (32),
    .p_max_outstanding (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .req0_msg    (req0_msg),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .req1_msg    (req1_msg),
    .resp0_val   (resp0_val),
    .resp0_rdy   (resp0_rdy),
    .resp0_msg   (resp0_msg),
    .resp1_val   (resp1_val),
    .resp1_rdy   (resp1_rdy),
    .resp1_msg   (resp1_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg)
  );

  logic [Q-1:0] q_req0[$];
  logic [Q-1:0] q_req1[$];
  logic [P-1:0] memq[$];
  logic [Q:0]   exp_mreq[$];
  logic [P:0]   exp_resp[$];

  int n_checks   = 0;
  int n_pass     = 0;
  int resp1_seen = 0;

  logic         s_f0, s_f1, s_fm, s_fr;
  logic [Q-1:0] s_mmsg;
  logic [Q:0]   em;
  logic [P:0]   er;
  logic         hv, hp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 128'(act), 128'(exp));
  endtask

  function automatic logic [Q-1:0] mk_req(input logic [7:0] opq, input logic [31:0] addr,
                                          input logic [31:0] data);
    return {3'd0, opq, addr, 2'd0, data};
  endfunction

  // Memory model: read data is the request data xor its address.
  function automatic logic [P-1:0] mem_reply(input logic [Q-1:0] r);
    return {r[76:74], r[73:66], 2'b00, r[33:32], r[31:0] ^ r[65:34]};
  endfunction

  task automatic drive();
    req0_val    = q_req0.size() != 0;
    req0_msg    = req0_val ? q_req0[0] : '0;
    req1_val    = q_req1.size() != 0;
    req1_msg    = req1_val ? q_req1[0] : '0;
    memresp_val = memq.size() != 0;
    memresp_msg = memresp_val ? memq[0] : '0;
  endtask

  // Requests must be added in the order they are expected to be granted.
  task automatic add_req(input logic port, input logic [Q-1:0] msg);
    if (port) q_req1.push_back(msg);
    else      q_req0.push_back(msg);
    exp_mreq.push_back({port, msg});
    exp_resp.push_back({port, mem_reply(msg)});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((q_req0.size() != 0 || q_req1.size() != 0 || memq.size() != 0 ||
            exp_mreq.size() != 0 || exp_resp.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (k < budget) n_pass++;
    else $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
  endtask

  // Handshakes are sampled mid-cycle; they complete on the following edge.
  always @(negedge clk) begin
    s_f0   <= req0_val && req0_rdy;
    s_f1   <= req1_val && req1_rdy;
    s_fm   <= memreq_val && memreq_rdy;
    s_mmsg <= memreq_msg;
    s_fr   <= memresp_val && memresp_rdy;
  end

  always @(posedge clk) begin
    #1;
    if (s_f0) void'(q_req0.pop_front());
    if (s_f1) void'(q_req1.pop_front());
    if (s_fr) void'(memq.pop_front());
    if (s_fm) memq.push_back(mem_reply(s_mmsg));
    drive();
  end

  // Monitor: compare every presented transfer against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (memreq_val && memreq_rdy) begin
        if (exp_mreq.size() == 0) begin
          check1("memreq_unexpected", memreq_val, 1'b0);
        end else begin
          em = exp_mreq.pop_front();
          check1("memreq_port", req1_rdy, em[Q]);
          check("memreq_msg", 128'(memreq_msg), 128'(em[Q-1:0]));
        end
      end
      if (resp0_val || resp1_val) begin
        hv = exp_resp.size() != 0;
        er = hv ? exp_resp[0] : '0;
        hp = er[P];
        check1("resp0_val_route", resp0_val, hv && !hp);
        check1("resp1_val_route", resp1_val, hv && hp);
        if (resp1_val) resp1_seen++;
      end
      if (memresp_val && memresp_rdy) begin
        if (exp_resp.size() == 0) begin
          check1("memresp_unexpected", memresp_rdy, 1'b0);
        end else begin
          er = exp_resp.pop_front();
          check1("resp_port", resp1_val, er[P]);
          check("resp_msg", 128'(resp1_val ? resp1_msg : resp0_msg), 128'(er[P-1:0]));
        end
      end
    end
  end

  task automatic check_all_idle_outputs(input string tag);
    check1({tag, "_memreq_val"}, memreq_val, 1'b0);
    check1({tag, "_req0_rdy"}, req0_rdy, 1'b0);
    check1({tag, "_req1_rdy"}, req1_rdy, 1'b0);
    check1({tag, "_resp0_val"}, resp0_val, 1'b0);
    check1({tag, "_resp1_val"}, resp1_val, 1'b0);
    check1({tag, "_memresp_rdy"}, memresp_rdy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [Q-1:0] first_msg;
    reset      = 1'b0;
    memreq_rdy = 1'b1;
    resp0_rdy  = 1'b1;
    resp1_rdy  = 1'b1;
    // Alternation traffic is queued during reset so both requesters are valid at release.
    for (int i = 0; i < 8; i++) begin
      add_req(1'b0, mk_req(8'(i), 32'h0000_1000 + 32'(4 * i), 32'h1111_0000 + 32'(i)));
      add_req(1'b1, mk_req(8'(8'h80 + i), 32'h0000_2000 + 32'(4 * i), 32'h2222_0000 + 32'(i)));
    end
    drive();
    tick();
    tick();
    @(negedge clk);
    check_all_idle_outputs("reset");
    check("reset_outstanding", 128'(dut.outstanding), 128'(0));
    tick();
    reset = 1'b1;
    wait_idle("alternate_drain", 200);

    // Single requester reads, memory replies next cycle.
    resp1_seen = 0;
    add_req(1'b0, mk_req(8'h10, 32'h0000_0100, 32'hAAAA_0001));
    add_req(1'b0, mk_req(8'h11, 32'h0000_0104, 32'hAAAA_0002));
    add_req(1'b0, mk_req(8'h12, 32'h0000_0108, 32'hAAAA_0003));
    drive();
    wait_idle("port0_reads_drain", 100);
    check("port0_reads_resp1_seen", 128'(resp1_seen), 128'(0));

    // Stalled memreq: last grant was port 0, so port 1 holds the grant.
    memreq_rdy = 1'b0;
    first_msg  = mk_req(8'hA0, 32'h0000_3000, 32'h3333_0000);
    add_req(1'b1, first_msg);
    add_req(1'b0, mk_req(8'h20, 32'h0000_3100, 32'h3333_0001));
    add_req(1'b1, mk_req(8'hA1, 32'h0000_3004, 32'h3333_0002));
    add_req(1'b0, mk_req(8'h21, 32'h0000_3104, 32'h3333_0003));
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check1("stall_memreq_val", memreq_val, 1'b1);
      check("stall_memreq_msg", 128'(memreq_msg), 128'(first_msg));
      check1("stall_req0_rdy", req0_rdy, 1'b0);
      check1("stall_req1_rdy", req1_rdy, 1'b0);
      tick();
    end
    memreq_rdy = 1'b1;
    wait_idle("stall_drain", 100);

    // Outstanding limit: responses held off, 6 requests, only 4 may issue.
    resp0_rdy = 1'b0;
    resp1_rdy = 1'b0;
    for (int i = 0; i < 6; i++)
      add_req(1'b0, mk_req(8'(8'h30 + i), 32'h0000_4000 + 32'(4 * i), 32'h4444_0000 + 32'(i)));
    drive();
    for (int c = 0; c < 7; c++) tick();
    @(negedge clk);
    check("full_outstanding", 128'(dut.outstanding), 128'(4));
    check1("full_req0_rdy", req0_rdy, 1'b0);
    check1("full_memreq_val", memreq_val, 1'b0);
    check("full_pending", 128'(q_req0.size()), 128'(2));
    check1("full_memresp_rdy", memresp_rdy, 1'b0);
    tick();
    resp0_rdy = 1'b1;
    @(negedge clk);
    check1("full_pop_req0_rdy", req0_rdy, 1'b0);
    check1("full_pop_memresp_rdy", memresp_rdy, 1'b1);
    tick();
    resp0_rdy = 1'b0;
    @(negedge clk);
    check("after_pop_outstanding", 128'(dut.outstanding), 128'(3));
    check1("after_pop_req0_rdy", req0_rdy, 1'b1);
    tick();
    @(negedge clk);
    check("refill_outstanding", 128'(dut.outstanding), 128'(4));
    check("refill_pending", 128'(q_req0.size()), 128'(1));
    check1("refill_req0_rdy", req0_rdy, 1'b0);
    tick();
    resp0_rdy = 1'b1;
    wait_idle("full_drain", 100);

    // Interleaved 0,1,1,0 with port 1 back-pressured: responses stay in order.
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b0;
    add_req(1'b0, mk_req(8'h40, 32'h0000_5000, 32'h5555_0000));
    drive();
    tick();
    add_req(1'b1, mk_req(8'hC0, 32'h0000_5100, 32'h5555_0001));
    drive();
    tick();
    add_req(1'b1, mk_req(8'hC1, 32'h0000_5104, 32'h5555_0002));
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check1("bp_resp1_val", resp1_val, 1'b1);
      check1("bp_resp0_val", resp0_val, 1'b0);
      check1("bp_memresp_rdy", memresp_rdy, 1'b0);
      tick();
      if (c == 0) begin
        add_req(1'b0, mk_req(8'h41, 32'h0000_5004, 32'h5555_0003));
        drive();
      end
    end
    check("bp_issued_despite_stall", 128'(exp_mreq.size()), 128'(0));
    resp1_rdy = 1'b1;
    wait_idle("bp_drain", 100);

    // Reset with 3 requests in flight.
    resp0_rdy = 1'b0;
    resp1_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      add_req(1'b0, mk_req(8'(8'h50 + i), 32'h0000_6000 + 32'(4 * i), 32'h6666_0000 + 32'(i)));
    drive();
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    check("pre_reset_outstanding", 128'(dut.outstanding), 128'(3));
    tick();
    reset = 1'b0;
    q_req0.delete();
    q_req1.delete();
    memq.delete();
    exp_mreq.delete();
    exp_resp.delete();
    add_req(1'b0, mk_req(8'h60, 32'h0000_7000, 32'h7777_0000));
    add_req(1'b1, mk_req(8'hE0, 32'h0000_7100, 32'h7777_0001));
    drive();
    @(negedge clk);
    check_all_idle_outputs("midreset");
    tick();
    @(negedge clk);
    check("midreset_outstanding", 128'(dut.outstanding), 128'(0));
    check_all_idle_outputs("midreset_held");
    tick();
    reset     = 1'b1;
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    wait_idle("post_reset_drain", 100);
    @(negedge clk);
    check("final_outstanding", 128'(dut.outstanding), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arb_2port.md
MEM_REQ_ARB_2PORT -- requirements
Module: mem_req_arb_2port

Interface
REQ-001 SHALL have parameter p_opaque_nbits, default 8, mem message opaque width.
REQ-002 SHALL have parameter p_addr_nbits, default 32, mem message address width.
REQ-003 SHALL have parameter p_data_nbits, default 32, mem message data width.
REQ-004 SHALL have parameter p_max_outstanding, default 4, in-flight request limit; power of two, at least 2.
REQ-005 SHALL have ports as follows; Q = VC_MEM_REQ_MSG_NBITS(o,a,d), P = VC_MEM_RESP_MSG_NBITS(o,d).
REQ-006 clk  in  1  clock; reset reset, synchronous, active-low.
REQ-007 reset  in  1  synchronous active-low reset.
REQ-008 reqN_val / reqN_rdy / reqN_msg  in/out/in  1/1/Q  requester N request port, N = 0,1.
REQ-009 respN_val / respN_rdy / respN_msg  out/in/out  1/1/P  requester N response port, N = 0,1.
REQ-010 memreq_val / memreq_rdy / memreq_msg  out/in/out  1/1/Q  shared single-port memory request.
REQ-011 memresp_val / memresp_rdy / memresp_msg  in/out/in  1/1/P  shared memory response, in request order.

Function
REQ-012 SHALL grant at most one requester per cycle, combinationally; memreq_msg equals the granted reqN_msg unmodified.
REQ-013 SHALL arbitrate round-robin with a 1-bit priority pointer; when both are valid, the pointed port wins.
REQ-014 SHALL move the priority pointer to the non-granted port only when memreq_val && memreq_rdy (fire); a stalled grant holds.
REQ-015 SHALL set memreq_val = (req0_val || req1_val) && !tag_full; reqN_rdy = grantN && memreq_rdy && !tag_full.
REQ-016 SHALL push the granted port ID into an in-order tag FIFO of depth p_max_outstanding on each request fire.
REQ-017 SHALL route a memory response to the port at the tag FIFO head: respN_val = memresp_val && !tag_empty && head==N; respN_msg = memresp_msg.
REQ-018 SHALL drive memresp_rdy = respH_rdy for head port H, and 0 when the tag FIFO is empty.
REQ-019 SHALL pop the tag FIFO on memresp_val && memresp_rdy.
REQ-020 Simultaneous push and pop SHALL both take effect; the count is unchanged.
REQ-021 When full, pushes SHALL be blocked even if a pop occurs in the same cycle; no combinational rdy path from memresp to reqN.
REQ-022 SHALL keep an outstanding counter of width clog2(p_max_outstanding)+1, with no wrap; incrementing past the limit or decrementing below 0 SHALL be an assertion error.
REQ-023 A memresp_val while the tag FIFO is empty SHALL be an assertion error; respN_val stays 0.
REQ-024 Back-pressure on one response port SHALL stall all responses (in-order) but not request issue until full.

Reset
REQ-025 While reset==0 at a clk edge: priority pointer=0, tag FIFO empty, counter=0.
REQ-026 During and after reset, all *_val and *_rdy outputs SHALL be 0 until the first cycle with reset==1.
REQ-027 Reset mid-operation SHALL discard in-flight tags; the environment resets the memory at the same time.
REQ-028 Assertions SHALL check req*_val, resp*_rdy, memreq_rdy and memresp_val are not X when reset==1.

Structure
REQ-029 A package mem_arb_pkg SHALL hold the port-ID type (1 bit), the constants PORT0=0 and PORT1=1, and the clog2-based count width function.
REQ-030 The tag FIFO SHALL be one sub-module, mem_arb_tag_fifo: a normal queue, 1-bit entries, depth p_max_outstanding, with full, empty and head outputs.
REQ-031 The arbiter logic and counter SHALL live in the top level; there is no other hierarchy.

Verification
REQ-032 Only req0 valid, 3 reads to 0x100/0x104/0x108, memory replies next cycle -> 3 resp0 in order, resp1_val never 1.
REQ-033 req0 and req1 valid continuously for 8 requests each -> grants alternate 0,1,0,1...; the first grant is port 0 after reset.
REQ-034 memreq_rdy=0 for 5 cycles with both valid -> grant stays on the same port, no pointer change, memreq_msg stable.
REQ-035 p_max_outstanding=4, memresp_rdy path held off, 6 requests -> exactly 4 issue, req*_rdy=0 after that, count=4; after 1 response, 1 more issues.
REQ-036 Interleaved requests 0,1,1,0, with resp1_rdy=0 for 3 cycles -> the first response reaches port 0, then the system stalls, then port 1 receives both in order, then port 0.
REQ-037 reset=0 asserted with 3 outstanding -> next cycle the counter is 0 and all val/rdy outputs are 0; traffic after reset routes correctly.
